// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Word-addressed data memory on the CPU load/store path. An FSM adds a
// programmable number of wait states to every access and reports completion
// with a one-cycle ready pulse. Illegal, out-of-range and misaligned accesses
// are flagged on that same pulse and have no side effects.
//
// Optional feature macro: DMEM_SUBWORD_EN
//   defined   : funct3 selects byte/half/word access (LB/LH/LW/LBU/LHU,
//               SB/SH/SW); sub-word stores merge into the addressed word.
//   undefined : funct3 is ignored; every access is a 32-bit word.
//
// Parameters
//   ADDR_W    width of the byte address
//   DEPTH     number of 32-bit words; word index = alu_result[ADDR_W-1:2]
//   WAIT_CYC  wait states per access, 0..7
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   en_fetch_data  in   load request, held until mem_ready
//   en_store_data  in   store request, held until mem_ready
//   alu_result     in   byte address
//   Rdata2         in   store data (low bytes used for SB/SH)
//   funct3         in   access size/sign (only with DMEM_SUBWORD_EN)
//   data_m         out  load result, held until the next load completes
//   mem_ready      out  one-cycle completion pulse
//   mem_busy       out  high whenever the FSM is not idle
//   addr_fault     out  qualifies mem_ready: access was illegal and suppressed
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_fetch_data,
    input  logic              en_store_data,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [31:0]       Rdata2,
    input  logic [2:0]        funct3,
    output logic [31:0]       data_m,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              addr_fault
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] WAIT_INIT = (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic              store_q;
    logic              conflict_q;

    logic [31:0] mem [DEPTH];

    // Current access: live inputs while idle (needed when WAIT_CYC=0 skips the
    // wait state), latched copies afterwards.
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [2:0]        cur_f3;
    logic              cur_store;
    logic              cur_conflict;

    logic              req;
    logic              access_go;
    logic [ADDR_W-1:0] word_idx;
    logic              range_fault;
    logic              misalign;
    logic              size_bad;
    logic              cur_fault;
    logic [IDX_W-1:0]  mem_idx;
    logic [31:0]       rd_word;
    logic [31:0]       ld_val;
    logic [31:0]       wr_word;
    logic              mem_we;

    assign req = en_fetch_data | en_store_data;

    always_comb begin
        if (state_q == StIdle) begin
            cur_addr     = alu_result;
            cur_wdata    = Rdata2;
            cur_f3       = funct3;
            cur_store    = en_store_data;
            cur_conflict = en_fetch_data & en_store_data;
        end else begin
            cur_addr     = addr_q;
            cur_wdata    = wdata_q;
            cur_f3       = funct3_q;
            cur_store    = store_q;
            cur_conflict = conflict_q;
        end
    end

    // The memory side effect happens on the edge that enters DONE.
    assign access_go = ((state_q == StIdle) && req && (WAIT_CYC == 0)) ||
                       ((state_q == StWait) && (cnt_q == 3'd0));

    assign word_idx    = {2'b00, cur_addr[ADDR_W-1:2]};
    assign range_fault = (word_idx >= ADDR_W'(DEPTH));
    assign mem_idx     = cur_addr[IDX_W+1:2];
    assign rd_word     = mem[mem_idx];

`ifdef DMEM_SUBWORD_EN
    logic [4:0]  shamt_b;
    logic [4:0]  shamt_h;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign shamt_b = {cur_addr[1:0], 3'b000};
    assign shamt_h = {cur_addr[1], 4'b0000};
    assign byte_v  = 8'(rd_word >> shamt_b);
    assign half_v  = 16'(rd_word >> shamt_h);

    always_comb begin
        size_bad = 1'b0;
        misalign = 1'b0;
        ld_val   = rd_word;
        wr_word  = cur_wdata;
        case (cur_f3)
            3'b000: begin
                ld_val  = {{24{byte_v[7]}}, byte_v};
                wr_word = (rd_word & ~(32'h0000_00ff << shamt_b)) |
                          ({24'h0, cur_wdata[7:0]} << shamt_b);
            end
            3'b001: begin
                misalign = cur_addr[0];
                ld_val   = {{16{half_v[15]}}, half_v};
                wr_word  = (rd_word & ~(32'h0000_ffff << shamt_h)) |
                           ({16'h0, cur_wdata[15:0]} << shamt_h);
            end
            3'b010: begin
                misalign = |cur_addr[1:0];
            end
            // Unsigned codes exist for loads only.
            3'b100: begin
                size_bad = cur_store;
                ld_val   = {24'h0, byte_v};
            end
            3'b101: begin
                size_bad = cur_store;
                misalign = cur_addr[0];
                ld_val   = {16'h0, half_v};
            end
            default: begin
                size_bad = 1'b1;
            end
        endcase
    end
`else
    logic unused_f3;

    assign unused_f3 = ^cur_f3;
    assign size_bad  = 1'b0;
    assign misalign  = |cur_addr[1:0];
    assign ld_val    = rd_word;
    assign wr_word   = cur_wdata;
`endif

    assign cur_fault = cur_conflict | range_fault | misalign | size_bad;

    // rst gating stops a WAIT_CYC=0 store from landing on an edge during reset.
    assign mem_we = access_go & cur_store & ~cur_fault & ~rst;

    // Array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            funct3_q   <= 3'd0;
            store_q    <= 1'b0;
            conflict_q <= 1'b0;
            data_m     <= 32'h0;
            mem_ready  <= 1'b0;
            mem_busy   <= 1'b0;
            addr_fault <= 1'b0;
        end else begin
            mem_ready  <= 1'b0;
            addr_fault <= 1'b0;

            if (access_go) begin
                mem_ready  <= 1'b1;
                addr_fault <= cur_fault;
                if (!cur_store && !cur_fault) begin
                    data_m <= ld_val;
                end
            end

            case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q     <= alu_result;
                        wdata_q    <= Rdata2;
                        funct3_q   <= funct3;
                        store_q    <= en_store_data;
                        conflict_q <= en_fetch_data & en_store_data;
                        mem_busy   <= 1'b1;
                        if (WAIT_CYC == 0) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StDone: begin
                    state_q  <= StIdle;
                    mem_busy <= 1'b0;
                end
                default: begin
                    state_q  <= StIdle;
                    mem_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: WAIT_CYC=2, instance B: WAIT_CYC=0
    logic        ld_a, st_a, rdy_a, busy_a, flt_a;
    logic [31:0] addr_a, wd_a, dm_a;
    logic [2:0]  f3_a;
    logic        ld_b, st_b, rdy_b, busy_b, flt_b;
    logic [31:0] addr_b, wd_b, dm_b;
    logic [2:0]  f3_b;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_ctrl #(.ADDR_W(32), .DEPTH(1024), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst), .en_fetch_data(ld_a), .en_store_data(st_a),
        .alu_result(addr_a), .Rdata2(wd_a), .funct3(f3_a), .data_m(dm_a),
        .mem_ready(rdy_a), .mem_busy(busy_a), .addr_fault(flt_a)
    );

    data_mem_ctrl #(.ADDR_W(32), .DEPTH(1024), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .en_fetch_data(ld_b), .en_store_data(st_b),
        .alu_result(addr_b), .Rdata2(wd_b), .funct3(f3_b), .data_m(dm_b),
        .mem_ready(rdy_b), .mem_busy(busy_b), .addr_fault(flt_b)
    );

    task automatic drive(input int sel, input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
        if (sel == 0) begin
            ld_a = ld; st_a = st; addr_a = a; wd_a = wd; f3_a = f3;
        end else begin
            ld_b = ld; st_b = st; addr_b = a; wd_b = wd; f3_b = f3;
        end
    endtask

    // One CPU access: request held until mem_ready. lat = cycles from the
    // request cycle to the ready cycle, -1 if no ready within the budget.
    task automatic do_acc(input int sel, input logic ld, input logic st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output int lat, output logic flt);
        @(posedge clk);
        #1;
        drive(sel, ld, st, a, wd, f3);
        lat = -1;
        flt = 1'b0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (((sel == 0) ? rdy_a : rdy_b) === 1'b1) begin
                lat = k;
                flt = (sel == 0) ? flt_a : flt_b;
                drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
            end
        end
        if (lat < 0) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (dm_a !== 32'h0) begin n_err++; $display("FAIL reset_data_m: got %h want 00000000", dm_a); end
        n_cmp++; if (rdy_a !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", rdy_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_cmp++; if (flt_a !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", flt_a); end
        n_cmp++; if (dm_b !== 32'h0) begin n_err++; $display("FAIL reset_data_m_w0: got %h want 00000000", dm_b); end
    endtask

    task automatic test_word_rw();
        int lat; logic flt;
        do_acc(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, lat, flt);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL sw_latency: got %0d want 3", lat); end
        n_cmp++; if (flt !== 1'b0) begin n_err++; $display("FAIL sw_fault: got %b want 0", flt); end
        do_acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, lat, flt);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL lw_latency: got %0d want 3", lat); end
        n_cmp++; if (flt !== 1'b0) begin n_err++; $display("FAIL lw_fault: got %b want 0", flt); end
        n_cmp++; if (dm_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data: got %h want deadbeef", dm_a); end
    endtask

    task automatic test_back_to_back();
        int lat; logic flt; int r1, r2; logic [31:0] d1, d2;
        do_acc(1, 1'b0, 1'b1, 32'h0, 32'h0A0A0A0A, 3'b010, lat, flt);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL w0_sw_latency: got %0d want 1", lat); end
        do_acc(1, 1'b0, 1'b1, 32'h4, 32'h0B0B0B0B, 3'b010, lat, flt);
        r1 = -1; r2 = -1; d1 = 32'h0; d2 = 32'h0;
        @(posedge clk);
        #1 drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        for (int c = 0; c < 12 && r2 < 0; c++) begin
            @(negedge clk);
            if (rdy_b === 1'b1) begin
                n_cmp++;
                if (busy_b !== 1'b1) begin n_err++; $display("FAIL b2b_busy_done: got %b want 1", busy_b); end
                if (r1 < 0) begin
                    r1 = c; d1 = dm_b;
                    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 3'b010);  // still held, next address
                end else begin
                    r2 = c; d2 = dm_b;
                    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
                end
            end
        end
        if (r2 < 0) drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        n_cmp++; if (r1 !== 1) begin n_err++; $display("FAIL b2b_first_ready: got %0d want 1", r1); end
        n_cmp++; if (r2 - r1 !== 2) begin n_err++; $display("FAIL b2b_spacing: got %0d want 2", r2 - r1); end
        n_cmp++; if (d1 !== 32'h0A0A0A0A) begin n_err++; $display("FAIL b2b_data0: got %h want 0a0a0a0a", d1); end
        n_cmp++; if (d2 !== 32'h0B0B0B0B) begin n_err++; $display("FAIL b2b_data1: got %h want 0b0b0b0b", d2); end
    endtask

    task automatic test_faults();
        int lat; logic flt;
        do_acc(0, 1'b1, 1'b0, 32'h1000, 32'h0, 3'b010, lat, flt);
        n_cmp++; if (flt !== 1'b1) begin n_err++; $display("FAIL range_fault: got %b want 1", flt); end
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL range_latency: got %0d want 3", lat); end
        n_cmp++; if (dm_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL range_data_held: got %h want deadbeef", dm_a); end
        do_acc(0, 1'b1, 1'b0, 32'h6, 32'h0, 3'b010, lat, flt);
        n_cmp++; if (flt !== 1'b1) begin n_err++; $display("FAIL misalign_fault: got %b want 1", flt); end
        n_cmp++; if (dm_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL misalign_data_held: got %h want deadbeef", dm_a); end
        do_acc(0, 1'b1, 1'b1, 32'h10, 32'h12345678, 3'b010, lat, flt);
        n_cmp++; if (flt !== 1'b1) begin n_err++; $display("FAIL conflict_fault: got %b want 1", flt); end
        do_acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, lat, flt);
        n_cmp++; if (dm_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL conflict_mem_kept: got %h want deadbeef", dm_a); end
    endtask

    task automatic test_subword();
        int lat; logic flt;
        do_acc(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 3'b010, lat, flt);
`ifdef DMEM_SUBWORD_EN
        do_acc(0, 1'b0, 1'b1, 32'h21, 32'h000000AA, 3'b000, lat, flt);
        n_cmp++; if (flt !== 1'b0) begin n_err++; $display("FAIL sb_fault: got %b want 0", flt); end
        do_acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, lat, flt);
        n_cmp++; if (dm_a !== 32'h1122AA44) begin n_err++; $display("FAIL sb_merge: got %h want 1122aa44", dm_a); end
        do_acc(0, 1'b1, 1'b0, 32'h21, 32'h0, 3'b000, lat, flt);
        n_cmp++; if (dm_a !== 32'hFFFFFFAA) begin n_err++; $display("FAIL lb_sext: got %h want ffffffaa", dm_a); end
        do_acc(0, 1'b1, 1'b0, 32'h21, 32'h0, 3'b100, lat, flt);
        n_cmp++; if (dm_a !== 32'h000000AA) begin n_err++; $display("FAIL lbu_zext: got %h want 000000aa", dm_a); end
        do_acc(0, 1'b1, 1'b0, 32'h21, 32'h0, 3'b001, lat, flt);
        n_cmp++; if (flt !== 1'b1) begin n_err++; $display("FAIL lh_misalign: got %b want 1", flt); end
        do_acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b011, lat, flt);
        n_cmp++; if (flt !== 1'b1) begin n_err++; $display("FAIL bad_funct3: got %b want 1", flt); end
`else
        do_acc(0, 1'b0, 1'b1, 32'h22, 32'h99999999, 3'b000, lat, flt);
        n_cmp++; if (flt !== 1'b1) begin n_err++; $display("FAIL sw_misalign: got %b want 1", flt); end
        do_acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b000, lat, flt);
        n_cmp++; if (flt !== 1'b0) begin n_err++; $display("FAIL f3_ignored: got %b want 0", flt); end
        n_cmp++; if (dm_a !== 32'h11223344) begin n_err++; $display("FAIL word_kept: got %h want 11223344", dm_a); end
`endif
    endtask

    task automatic test_reset_mid();
        int lat; logic flt; int seen;
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 3'b010);
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy_a); end
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rdy_a === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midrst_ready: got %0d pulses want 0", seen); end
        do_acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, lat, flt);
        n_cmp++; if (dm_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL midrst_old_value: got %h want deadbeef", dm_a); end
    endtask

    // Byte-level reference model of the memory; expectations follow the access rules.
    task automatic test_random();
        logic [7:0]  ref_b [int unsigned];
        logic [31:0] a, wd, v, exp_dm;
        logic [2:0]  f3;
        logic        ld, st, flt, exp_f;
        int          lat, sz, r;
`ifdef DMEM_SUBWORD_EN
        logic [2:0]  f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`endif
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            do_acc(0, 1'b0, 1'b1, 32'(w * 4), wd, 3'b010, lat, flt);
            for (int i = 0; i < 4; i++) ref_b[32'(w * 4 + i)] = wd[8*i +: 8];
            n_cmp++;
            if (flt !== 1'b0 || lat !== 3) begin
                n_err++; $display("FAIL rand_init[%0d]: got fault=%b lat=%0d want 0/3", w, flt, lat);
            end
        end
        do_acc(0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010, lat, flt);
        exp_dm = {ref_b[3], ref_b[2], ref_b[1], ref_b[0]};
        n_cmp++; if (dm_a !== exp_dm) begin n_err++; $display("FAIL rand_first_lw: got %h want %h", dm_a, exp_dm); end

        for (int it = 0; it < 80; it++) begin
            r  = int'($urandom_range(0, 9));
            wd = $urandom;
`ifdef DMEM_SUBWORD_EN
            f3 = f3_tab[$urandom_range(0, 4)];
`else
            f3 = 3'($urandom_range(0, 7));
`endif
            if (r == 9) begin
                ld = 1'b1; st = 1'b1;
            end else begin
                st = 1'($urandom_range(0, 1)); ld = ~st;
            end
`ifdef DMEM_SUBWORD_EN
            if (st && !ld) f3[2] = 1'b0;
            sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
`else
            sz = 4;
`endif
            if (r == 7)      a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
            else if (r == 8) a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
            else if (r == 6) a = 32'($urandom_range(0, 255));
            else             a = 32'($urandom_range(0, 255)) & ~(32'(sz) - 32'd1);
            exp_f = (ld && st) || ((a >> 2) >= 32'd1024) || ((a % 32'(sz)) != 32'd0);

            do_acc(0, ld, st, a, wd, f3, lat, flt);

            if (!exp_f) begin
                if (st) begin
                    for (int i = 0; i < sz; i++) ref_b[a + 32'(i)] = wd[8*i +: 8];
                end else begin
                    v = 32'h0;
                    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_b[a + 32'(i)];
                    if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
                    if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
                    exp_dm = v;
                end
            end
            n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want 3", it, lat); end
            n_cmp++; if (flt !== exp_f) begin n_err++; $display("FAIL rand_fault[%0d] addr=%h: got %b want %b", it, a, flt, exp_f); end
            n_cmp++; if (dm_a !== exp_dm) begin n_err++; $display("FAIL rand_data_m[%0d] addr=%h: got %h want %h", it, a, dm_a, exp_dm); end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_back_to_back();
        test_faults();
        test_subword();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
